instr_loader_encoder: RTL

Boot-time instruction writer for the single-cycle RV32I core. Accepts decoded instruction fields (op, funct3, funct7_5, rd, rs1, rs2, imm) over a valid/ready stream and packs each into its 32-bit R/I/S/B machine encoding, so each field matches what the control unit and immediate extender later decode. Writes the words sequentially into instruction memory from word address 0. Holds the core in reset until the final word has landed.

---
 rtl/instr_loader_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_loader_encoder.sv
// Boot-time loader: packs decoded RV32I fields into R/I/S/B machine words and
// writes them sequentially into instruction memory while holding the core in reset.
module instr_loader_encoder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [IMM_WIDTH-1:0]      imm,
  input  logic                      last,
  output logic                      imem_we,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  output logic [DATA_WIDTH-1:0]     imem_wdata,
  output logic                      cpu_rst,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_WIDTH:0]       count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_WIDTH-1:0] OP_LOAD = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OP_IMM  = 7'b0010011;
  localparam logic [OP_WIDTH-1:0] OP_S    = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OP_B    = 7'b1100011;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [DATA_WIDTH-1:0]   enc_word;
  logic                    supported;
  logic                    full;

  assign full = &wr_ptr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc_word  = '0;
    supported = 1'b1;
    case (op)
      OP_R:           enc_word = {1'b0, funct7_5, 5'b00000, rs2, rs1, funct3, rd, op};
      OP_LOAD, OP_IMM: enc_word = {imm[11:0], rs1, funct3, rd, op};
      OP_S:           enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      OP_B:           enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      default:        supported = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (supported) begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr;
              imem_wdata <= enc_word;
              wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
              count      <= count + (ADDR_WIDTH+1)'(1);
            end else begin
              err <= 1'b1;
            end
            // A write into the top word ends the session even without last.
            if (last || (supported && full)) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state   <= S_DONE;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          cpu_rst  <= 1'b1;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
